// File: rtl/paddle_sprite_ctrl.sv
// Paddle sprite RAM controller: draw-position texel lookup plus
// host write port arbitrated against a whole-sprite fill engine.
module paddle_sprite_ctrl #(
  parameter int SPRITE_W = 150,
  parameter int SPRITE_H = 200,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PaddleX,
  input  logic [9:0]        PaddleY,
  input  logic              pix_req,
  output logic              pix_valid,
  output logic              pix_in_bounds,
  output logic [DATA_W-1:0] pix_index,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic              host_err,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we
);

  localparam int N = SPRITE_W * SPRITE_H;
  localparam logic [ADDR_W-1:0] SIZE = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(SPRITE_W);
  localparam logic [9:0] LIM_X = 10'(SPRITE_W);
  localparam logic [9:0] LIM_Y = 10'(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic inb;
  } s1_t;

  // texel coordinate relative to paddle corner
  logic [9:0]        lx;
  logic [9:0]        ly;
  logic              inb;
  logic [ADDR_W-1:0] taddr;

  always_comb begin
    lx    = DrawX - PaddleX;
    ly    = DrawY - PaddleY;
    inb   = (lx < LIM_X) && (ly < LIM_Y);
    taddr = '0;
    if (inb)
      taddr = ADDR_W'(ly) * ROW + ADDR_W'(lx);
  end

  s1_t s1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1               <= '0;
      ram_read_address <= '0;
      pix_valid        <= 1'b0;
      pix_in_bounds    <= 1'b0;
    end else begin
      s1.valid      <= pix_req;
      s1.inb        <= pix_req & inb;
      pix_valid     <= s1.valid;
      pix_in_bounds <= s1.inb;
      if (pix_req)
        ram_read_address <= taddr;
    end
  end

  assign pix_index = pix_in_bounds ? ram_read_data : '0;

  logic              host_hit;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] value;

  assign host_hit = host_we && (host_addr < SIZE);

  // host owns the write port on any in-range request; fill retries
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      value             <= '0;
      fill_busy         <= 1'b0;
      fill_done         <= 1'b0;
      host_ack          <= 1'b0;
      host_err          <= 1'b0;
      ram_we            <= 1'b0;
      ram_write_address <= '0;
      ram_data_in       <= '0;
    end else begin
      host_ack  <= host_we;
      host_err  <= host_we & ~host_hit;
      ram_we    <= 1'b0;
      fill_done <= 1'b0;
      if (host_hit) begin
        ram_we            <= 1'b1;
        ram_write_address <= host_addr;
        ram_data_in       <= host_data;
      end
      unique case (state)
        IDLE: begin
          if (fill_start) begin
            state     <= FILL;
            value     <= fill_value;
            cnt       <= '0;
            fill_busy <= 1'b1;
          end
        end
        FILL: begin
          if (!host_hit) begin
            ram_we            <= 1'b1;
            ram_write_address <= cnt;
            ram_data_in       <= value;
            if (cnt == LAST)
              state <= DONE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          fill_done <= 1'b1;
          fill_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_sprite_ctrl.sv
// Self-checking bench for paddle_sprite_ctrl with a behavioural
// sync-read RAM and an arithmetic reference model.
module tb_paddle_sprite_ctrl;

  localparam int W  = 150;
  localparam int H  = 200;
  localparam int AW = 19;
  localparam int DW = 2;
  localparam int N  = W * H;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [9:0]    DrawX, DrawY, PaddleX, PaddleY;
  logic          pix_req;
  logic          pix_valid, pix_in_bounds;
  logic [DW-1:0] pix_index;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_ack, host_err;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy, fill_done;
  logic [DW-1:0] ram_read_data;
  logic [AW-1:0] ram_read_address, ram_write_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;

  always #5 Clk = ~Clk;

  paddle_sprite_ctrl #(
    .SPRITE_W(W), .SPRITE_H(H), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .DrawX(DrawX), .DrawY(DrawY),
    .PaddleX(PaddleX), .PaddleY(PaddleY),
    .pix_req(pix_req), .pix_valid(pix_valid),
    .pix_in_bounds(pix_in_bounds), .pix_index(pix_index),
    .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .host_ack(host_ack),
    .host_err(host_err), .fill_start(fill_start),
    .fill_value(fill_value), .fill_busy(fill_busy),
    .fill_done(fill_done), .ram_read_data(ram_read_data),
    .ram_read_address(ram_read_address),
    .ram_write_address(ram_write_address),
    .ram_data_in(ram_data_in), .ram_we(ram_we)
  );

  // sprite RAM: synchronous read, read-before-write
  logic [1:0] mem [0:N-1];
  logic [1:0] init_vals [0:N-1];
  logic       init_go = 1'b0;

  always @(posedge Clk) begin
    if (int'(ram_read_address) < N)
      ram_read_data <= mem[int'(ram_read_address)];
    else
      ram_read_data <= 2'b00;
    if (init_go)
      for (int i = 0; i < N; i++) mem[i] <= init_vals[i];
    else if (ram_we && int'(ram_write_address) < N)
      mem[int'(ram_write_address)] <= ram_data_in;
  end

  int errors = 0;
  int checks = 0;
  int acks, dones, done_at;
  logic [20:0] wq[$];
  logic [20:0] eq[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: geometry from plain integer arithmetic
  function automatic void ref_pix(input int dx, input int dy,
                                  input int px, input int py,
                                  output bit inb, output int addr);
    int lx, ly;
    lx   = (dx - px + 1024) % 1024;
    ly   = (dy - py + 1024) % 1024;
    inb  = (lx < W) && (ly < H);
    addr = inb ? ly * W + lx : 0;
  endfunction

  task automatic load_mem();
    @(negedge Clk);
    init_go = 1'b1;
    @(negedge Clk);
    init_go = 1'b0;
  endtask

  task automatic idle_inputs();
    DrawX = 0; DrawY = 0; PaddleX = 0; PaddleY = 0;
    pix_req = 0; host_we = 0; host_addr = 0; host_data = 0;
    fill_start = 0; fill_value = 0;
  endtask

  task automatic fill_run(input logic [1:0] v, input int stall_at,
                          input int abort_at);
    done_at = -1; acks = 0; dones = 0;
    wq.delete();
    @(negedge Clk);
    fill_value = v;
    fill_start = 1'b1;
    @(negedge Clk);
    fill_start = 1'b0;
    check("fill_busy_start", 64'(fill_busy), 64'd1);
    for (int k = 1; k <= N + 20; k++) begin
      host_we = 1'b0;
      if (stall_at >= 0 && k > stall_at && k <= stall_at + 3) begin
        host_we   = 1'b1;
        host_addr = AW'(7 + k - stall_at - 1);
        host_data = 2'b11;
      end
      Reset_n = (k == abort_at) ? 1'b0 : 1'b1;
      @(negedge Clk);
      if (ram_we) wq.push_back({ram_write_address, ram_data_in});
      if (host_ack) acks++;
      if (fill_done) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
      if (done_at >= 0 && k >= done_at + 3) break;
      if (abort_at > 0 && k >= abort_at + 5) break;
    end
    host_we = 1'b0;
    Reset_n = 1'b1;
  endtask

  task automatic cmp_writes(input string name);
    int bad = 0;
    int n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++)
      if (wq[i] !== eq[i]) bad++;
    check({name, "_len"}, 64'(wq.size()), 64'(eq.size()));
    check({name, "_seq"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    int         dx, dy, px, py;
    int         exp_addr;
    bit         exp_inb;
    logic [1:0] exp_idx;
  } rv_t;

  rv_t vec [8];

  initial begin
    vec[0] = '{103, 52, 100, 50, 303, 1, 2'd2};
    vec[1] = '{99, 52, 100, 50, 0, 0, 2'd0};
    vec[2] = '{250, 52, 100, 50, 0, 0, 2'd0};
    vec[3] = '{103, 250, 100, 50, 0, 0, 2'd0};
    vec[4] = '{249, 249, 100, 50, 29999, 1, 2'd3};
    vec[5] = '{100, 50, 100, 50, 0, 1, 2'd1};
    vec[6] = '{5, 10, 1000, 1000, 5129, 1, 2'd2};
    vec[7] = '{300, 50, 100, 50, 0, 0, 2'd0};

    for (int i = 0; i < N; i++) init_vals[i] = 2'b00;
    init_vals[303] = 2'd2;
    init_vals[29999] = 2'd3;
    init_vals[0] = 2'd1;
    init_vals[5129] = 2'd2;
    idle_inputs();
    Reset_n = 1'b0;
    load_mem();

    // reset with toggling inputs
    for (int c = 0; c < 3; c++) begin
      DrawX = 10'($urandom); DrawY = 10'($urandom);
      PaddleX = 10'($urandom); PaddleY = 10'($urandom);
      pix_req = 1'($urandom); host_we = 1'($urandom);
      host_addr = AW'($urandom_range(0, N + 10));
      host_data = 2'($urandom); fill_start = 1'($urandom);
      fill_value = 2'($urandom);
      @(negedge Clk);
      check("reset_outputs",
            64'({pix_valid, pix_in_bounds, pix_index, host_ack,
                 host_err, fill_busy, fill_done, ram_read_address,
                 ram_write_address, ram_data_in, ram_we}), 64'd0);
    end
    idle_inputs();
    Reset_n = 1'b1;
    @(negedge Clk);
    check("release_busy", 64'(fill_busy), 64'd0);
    check("release_valid", 64'(pix_valid), 64'd0);

    // directed read vectors
    foreach (vec[i]) begin
      DrawX = 10'(vec[i].dx); DrawY = 10'(vec[i].dy);
      PaddleX = 10'(vec[i].px); PaddleY = 10'(vec[i].py);
      pix_req = 1'b1;
      @(negedge Clk);
      pix_req = 1'b0;
      check("vec_addr", 64'(ram_read_address), 64'(vec[i].exp_addr));
      @(negedge Clk);
      check("vec_pix", 64'({pix_valid, pix_in_bounds, pix_index}),
            64'({1'b1, vec[i].exp_inb, vec[i].exp_idx}));
      @(negedge Clk);
      check("vec_idle_valid", 64'(pix_valid), 64'd0);
    end

    // random back-to-back reads against the model
    for (int i = 0; i < N; i++) init_vals[i] = 2'($urandom);
    load_mem();
    begin
      bit p_req = 0, p_inb = 0;
      int p_addr = 0;
      for (int c = 0; c < 400; c++) begin
        bit r, inb;
        int px, py, dx, dy, a;
        r  = ($urandom_range(0, 3) != 0);
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
        dx = (px + $urandom_range(0, 170) + 1014) % 1024;
        dy = (py + $urandom_range(0, 220) + 1014) % 1024;
        ref_pix(dx, dy, px, py, inb, a);
        DrawX = 10'(dx); DrawY = 10'(dy);
        PaddleX = 10'(px); PaddleY = 10'(py);
        pix_req = r;
        @(negedge Clk);
        if (r) check("rnd_addr", 64'(ram_read_address), 64'(a));
        check("rnd_pix", 64'({pix_valid, pix_in_bounds, pix_index}),
              64'({p_req, p_req & p_inb,
                   (p_req & p_inb) ? mem[p_addr] : 2'b00}));
        p_req = r; p_inb = inb; p_addr = a;
      end
      pix_req = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
    end

    // host writes while idle
    host_we = 1'b1; host_addr = AW'(42); host_data = 2'd1;
    @(negedge Clk);
    host_we = 1'b0;
    check("host_wr", 64'({ram_we, ram_write_address, ram_data_in,
                          host_ack, host_err}),
          64'({1'b1, AW'(42), 2'd1, 1'b1, 1'b0}));
    host_we = 1'b1; host_addr = AW'(N); host_data = 2'd3;
    @(negedge Clk);
    host_we = 1'b0;
    check("host_oor", 64'({ram_we, ram_write_address, ram_data_in,
                           host_ack, host_err}),
          64'({1'b0, AW'(42), 2'd1, 1'b1, 1'b1}));
    @(negedge Clk);
    check("host_ack_pulse", 64'({host_ack, host_err}), 64'd0);

    // fill with 3 host stalls at counter 500
    fill_run(2'd1, 500, -1);
    eq.delete();
    for (int a = 0; a < N; a++) begin
      if (a == 500)
        for (int h = 7; h <= 9; h++) eq.push_back({AW'(h), 2'b11});
      eq.push_back({AW'(a), 2'd1});
    end
    cmp_writes("fill_stall");
    check("fill_stall_done_at", 64'(done_at), 64'(N + 1 + 3));
    check("fill_stall_dones", 64'(dones), 64'd1);
    check("fill_stall_acks", 64'(acks), 64'd3);
    begin
      int bad = 0;
      for (int a = 0; a < N; a++)
        if (mem[a] !== ((a >= 7 && a <= 9) ? 2'b11 : 2'd1)) bad++;
      check("fill_stall_mem", 64'(bad), 64'd0);
    end

    // fill aborted by reset at counter 1000
    fill_run(2'd3, -1, 1001);
    check("abort_writes", 64'(wq.size()), 64'd1000);
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_idle", 64'({fill_busy, ram_we}), 64'd0);

    // full uncontended sweep after the abort
    fill_run(2'd2, -1, -1);
    eq.delete();
    for (int a = 0; a < N; a++) eq.push_back({AW'(a), 2'd2});
    cmp_writes("fill_full");
    check("fill_full_done_at", 64'(done_at), 64'(N + 1));
    check("fill_full_dones", 64'(dones), 64'd1);
    check("fill_full_busy_end", 64'(fill_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
